clk_set_ctrl: RTL and testbench

Time-set controller for the digital clock datapath. Takes debounced MODE and INC pushbutton levels plus the 1 Hz tick and sequences the seconds/minutes/hours counters through a run mode and three set modes. Outputs the gated seconds enable, single-cycle field-advance pulses and per-field blank strobes for display blinking. Sits between the pushbutton debouncers and the counter chain, replacing direct button-to-counter wiring.

---
 rtl/clk_set_pkg.sv | 16 +
 rtl/inc_repeat_gen.sv | 62 ++++++
 rtl/clk_set_ctrl.sv | 114 +++++++++++
 tb/tb_clk_set_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clk_set_pkg.sv
// Shared types and default timing constants for the clock time-set controller.
package clk_set_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  localparam int DEF_BLINK_CYC  = 25_000_000;
  localparam int DEF_TIMEOUT_S  = 10;
  localparam int DEF_REPEAT_DLY = 50_000_000;
  localparam int DEF_REPEAT_PER = 10_000_000;

endpackage

// File: rtl/inc_repeat_gen.sv
// INC rising-edge detector; with CLK_SET_AUTOREPEAT_EN defined it also emits
// auto-repeat requests while INC stays held and rep_en is set.
module inc_repeat_gen #(
  parameter int REPEAT_DLY = 50_000_000,
  parameter int REPEAT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_pb,
  input  logic rep_en,
  input  logic clr,
  output logic inc_req
);

  logic inc_q;
  logic edge_det;

  assign edge_det = inc_pb & ~inc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) inc_q <= 1'b0;
    else      inc_q <= inc_pb;
  end

`ifdef CLK_SET_AUTOREPEAT_EN
  localparam int CW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

  // cnt holds the number of cycles INC has been high before the current one
  logic [CW-1:0] cnt;
  logic          rep_ph;
  logic          rep_hit;

  assign rep_hit = rep_en & inc_pb & inc_q &
                   (rep_ph ? (cnt == PER_LAST) : (cnt == DLY_LAST));
  assign inc_req = edge_det | rep_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      rep_ph <= 1'b0;
    end else if (clr || !inc_pb) begin
      cnt    <= '0;
      rep_ph <= 1'b0;
    end else if (edge_det) begin
      cnt    <= CW'(1);
      rep_ph <= 1'b0;
    end else if (rep_hit) begin
      cnt    <= '0;
      rep_ph <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
`else
  logic unused_rep;
  assign unused_rep = ^{REPEAT_DLY[0], REPEAT_PER[0], rep_en, clr};
  assign inc_req    = edge_det;
`endif

endmodule

// File: rtl/clk_set_ctrl.sv
// Time-set controller: RUN / SET_HR / SET_MIN / SET_SEC sequencing, field
// pulses, blink strobes and idle timeout. Auto-repeat via CLK_SET_AUTOREPEAT_EN.
module clk_set_ctrl
  import clk_set_pkg::*;
#(
  parameter int BLINK_CYC  = DEF_BLINK_CYC,
  parameter int TIMEOUT_S  = DEF_TIMEOUT_S,
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_pb,
  input  logic       inc_pb,
  input  logic       tick_1hz,
  output logic       sec_enb,
  output logic       inc_hr,
  output logic       inc_min,
  output logic       clr_sec,
  output logic       blank_h,
  output logic       blank_m,
  output logic       blank_s,
  output logic [1:0] mode
);

  localparam int BW = $clog2(BLINK_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_S + 2);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYC - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_S > 0 ? TIMEOUT_S - 1 : 0);
  localparam bit            TO_EN   = (TIMEOUT_S > 0);

  state_e        state, state_n;
  logic          mode_q;
  logic          mode_edge;
  logic          inc_req;
  logic          inc_ok;
  logic          in_set;
  logic          to_expire;
  logic          state_chg;
  logic [TW-1:0] to_cnt;
  logic [BW-1:0] bl_cnt;
  logic          blink_ph;

  inc_repeat_gen #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc (
    .clk     (clk),
    .rst     (rst),
    .inc_pb  (inc_pb),
    .rep_en  ((state == SET_HR) || (state == SET_MIN)),
    .clr     (state_chg),
    .inc_req (inc_req)
  );

  assign mode_edge = mode_pb & ~mode_q;
  // MODE takes priority: a coincident INC edge is dropped
  assign inc_ok    = inc_req & ~mode_edge;
  assign in_set    = (state != RUN);
  assign to_expire = TO_EN && in_set && tick_1hz && (to_cnt == TO_LAST);

  always_comb begin
    state_n = state;
    if (mode_edge)                 state_n = state_e'(state + 2'd1);
    else if (to_expire && !inc_req) state_n = RUN;
  end

  assign state_chg = (state_n != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      mode_q  <= 1'b0;
      inc_hr  <= 1'b0;
      inc_min <= 1'b0;
      clr_sec <= 1'b0;
    end else begin
      state   <= state_n;
      mode_q  <= mode_pb;
      inc_hr  <= inc_ok & (state == SET_HR);
      inc_min <= inc_ok & (state == SET_MIN);
      clr_sec <= inc_ok & (state == SET_SEC);
    end
  end

  // Any button activity restarts the idle count; only 1 Hz ticks advance it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           to_cnt <= '0;
    else if (state_chg || !in_set || mode_edge || inc_req) to_cnt <= '0;
    else if (tick_1hz)                                  to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bl_cnt   <= '0;
      blink_ph <= 1'b0;
    end else if (state_chg) begin
      bl_cnt   <= '0;
      blink_ph <= 1'b0;
    end else if (bl_cnt == BL_LAST) begin
      bl_cnt   <= '0;
      blink_ph <= ~blink_ph;
    end else begin
      bl_cnt   <= bl_cnt + 1'b1;
    end
  end

  assign sec_enb = tick_1hz & (state == RUN);
  assign blank_h = blink_ph & (state == SET_HR);
  assign blank_m = blink_ph & (state == SET_MIN);
  assign blank_s = blink_ph & (state == SET_SEC);
  assign mode    = state;

endmodule

// File: tb/tb_clk_set_ctrl.sv
// Directed bench for clk_set_ctrl: vector table plus hand sequences for
// timeout/blink, MODE+INC collision, held INC and asynchronous reset.
module tb_clk_set_ctrl;

  logic       clk, rst, mode_pb, inc_pb, tick_1hz;
  logic       sec_enb, inc_hr, inc_min, clr_sec, blank_h, blank_m, blank_s;
  logic [1:0] mode;

`ifdef CLK_SET_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  clk_set_ctrl #(
    .BLINK_CYC  (4),
    .TIMEOUT_S  (3),
    .REPEAT_DLY (8),
    .REPEAT_PER (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_pb  (mode_pb),
    .inc_pb   (inc_pb),
    .tick_1hz (tick_1hz),
    .sec_enb  (sec_enb),
    .inc_hr   (inc_hr),
    .inc_min  (inc_min),
    .clr_sec  (clr_sec),
    .blank_h  (blank_h),
    .blank_m  (blank_m),
    .blank_s  (blank_s),
    .mode     (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {mode_pb, inc_pb, tick}; sec is pre-edge; md/pl = {hr,min,clr} post-edge
  typedef struct {
    logic [2:0] in;
    logic       sec;
    logic [1:0] md;
    logic [2:0] pl;
  } vec_t;

  vec_t vt[22];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic [2:0] in, input logic sec,
                              input logic [1:0] md, input logic [2:0] pl);
    vec_t v;
    v.in = in; v.sec = sec; v.md = md; v.pl = pl;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mode();
    mode_pb = 1'b1;
    step();
    mode_pb = 1'b0;
    step();
  endtask

  initial begin
    vt[0]  = mk(3'b001, 1'b1, 2'd0, 3'b000);
    vt[1]  = mk(3'b000, 1'b0, 2'd0, 3'b000);
    vt[2]  = mk(3'b001, 1'b1, 2'd0, 3'b000);
    vt[3]  = mk(3'b000, 1'b0, 2'd0, 3'b000);
    vt[4]  = mk(3'b001, 1'b1, 2'd0, 3'b000);
    vt[5]  = mk(3'b010, 1'b0, 2'd0, 3'b000);
    vt[6]  = mk(3'b000, 1'b0, 2'd0, 3'b000);
    vt[7]  = mk(3'b100, 1'b0, 2'd1, 3'b000);
    vt[8]  = mk(3'b101, 1'b0, 2'd1, 3'b000);
    vt[9]  = mk(3'b010, 1'b0, 2'd1, 3'b100);
    vt[10] = mk(3'b000, 1'b0, 2'd1, 3'b000);
    vt[11] = mk(3'b010, 1'b0, 2'd1, 3'b100);
    vt[12] = mk(3'b010, 1'b0, 2'd1, 3'b000);
    vt[13] = mk(3'b000, 1'b0, 2'd1, 3'b000);
    vt[14] = mk(3'b100, 1'b0, 2'd2, 3'b000);
    vt[15] = mk(3'b010, 1'b0, 2'd2, 3'b010);
    vt[16] = mk(3'b000, 1'b0, 2'd2, 3'b000);
    vt[17] = mk(3'b100, 1'b0, 2'd3, 3'b000);
    vt[18] = mk(3'b010, 1'b0, 2'd3, 3'b001);
    vt[19] = mk(3'b001, 1'b0, 2'd3, 3'b000);
    vt[20] = mk(3'b100, 1'b0, 2'd0, 3'b000);
    vt[21] = mk(3'b001, 1'b1, 2'd0, 3'b000);

    rst = 1'b0; mode_pb = 1'b0; inc_pb = 1'b0; tick_1hz = 1'b1;
    #3;
    chk2("rst.mode", mode, 2'd0);
    chk1("rst.sec_enb", sec_enb, 1'b1);
    chk1("rst.inc_hr", inc_hr, 1'b0);
    chk1("rst.inc_min", inc_min, 1'b0);
    chk1("rst.clr_sec", clr_sec, 1'b0);
    chk1("rst.blank", blank_h | blank_m | blank_s, 1'b0);
    tick_1hz = 1'b0;
    step();
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      {mode_pb, inc_pb, tick_1hz} = vt[i].in;
      #2;
      chk1($sformatf("vec%0d.sec_enb", i), sec_enb, vt[i].sec);
      step();
      chk2($sformatf("vec%0d.mode", i), mode, vt[i].md);
      chk1($sformatf("vec%0d.inc_hr", i), inc_hr, vt[i].pl[2]);
      chk1($sformatf("vec%0d.inc_min", i), inc_min, vt[i].pl[1]);
      chk1($sformatf("vec%0d.clr_sec", i), clr_sec, vt[i].pl[0]);
    end
    {mode_pb, inc_pb, tick_1hz} = 3'b000;

    // SET_MIN idle: blink every 4 cycles, timeout to RUN on the third tick
    press_mode();
    press_mode();
    for (int k = 1; k <= 13; k++) begin
      tick_1hz = (k == 2 || k == 6 || k == 10);
      #2;
      chk2($sformatf("to%0d.mode", k), mode, (k < 11) ? 2'd2 : 2'd0);
      chk1($sformatf("to%0d.blank_m", k), blank_m, (k < 11) ? 1'((k / 4) % 2) : 1'b0);
      chk1($sformatf("to%0d.blank_h", k), blank_h | blank_s, 1'b0);
      if (k == 10) chk1("to.sec_enb_frozen", sec_enb, 1'b0);
      step();
    end
    tick_1hz = 1'b0;

    // MODE and INC edges together in SET_HR
    press_mode();
    chk2("col.mode_pre", mode, 2'd1);
    mode_pb = 1'b1; inc_pb = 1'b1;
    step();
    chk2("col.mode", mode, 2'd2);
    chk1("col.inc_hr", inc_hr, 1'b0);
    chk1("col.inc_min", inc_min, 1'b0);
    mode_pb = 1'b0; inc_pb = 1'b0;
    step();
    chk1("col.inc_hr2", inc_hr, 1'b0);
    chk1("col.inc_min2", inc_min, 1'b0);
    press_mode();
    press_mode();
    chk2("col.mode_back", mode, 2'd0);

    // INC held 20 cycles in SET_HR
    press_mode();
    chk2("hold.mode", mode, 2'd1);
    for (int j = 0; j < 25; j++) begin
      inc_pb = (j < 20);
      #2;
      chk1($sformatf("hold%0d.inc_hr", j), inc_hr,
           (j == 1) || (AR && (j == 8 || j == 11 || j == 14 || j == 17 || j == 20)));
      chk1($sformatf("hold%0d.inc_min", j), inc_min, 1'b0);
      step();
    end

    // Asynchronous reset while a pulse is on the outputs
    inc_pb = 1'b1;
    step();
    #1;
    chk1("arst.pre_inc_hr", inc_hr, 1'b1);
    rst = 1'b0;
    #1;
    chk2("arst.mode", mode, 2'd0);
    chk1("arst.inc_hr", inc_hr, 1'b0);
    chk1("arst.inc_min", inc_min, 1'b0);
    chk1("arst.clr_sec", clr_sec, 1'b0);
    chk1("arst.blank", blank_h | blank_m | blank_s, 1'b0);
    inc_pb = 1'b0;
    step();
    rst = 1'b1;
    step();
    press_mode();
    chk2("arst.mode_after", mode, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
